// File: rtl/pri_ctrl.sv
// Privileged-operation sequencer: Zicsr read-modify-write, ECALL trap entry and MRET
// trap return, driving one CSR read port and one CSR write port.
module pri_ctrl #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned ECALL_CAUSE = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [2:0]      req_func3,
  input  logic [11:0]     req_csr_addr,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [4:0]      req_rd_addr,
  input  logic [XLEN-1:0] req_pc,
  output logic [11:0]     csr_raddr,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            rd_w_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_o,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            illegal_o,
  output logic            busy
);

  localparam logic [11:0] AddrMstatus = 12'h300;
  localparam logic [11:0] AddrMtvec   = 12'h305;
  localparam logic [11:0] AddrMepc    = 12'h341;
  localparam logic [11:0] AddrMcause  = 12'h342;

  typedef enum logic [3:0] {
    StIdle,
    StCsr,
    StTEpc,
    StTCause,
    StTStat,
    StTVec,
    StMStat,
    StMEpc,
    StErr
  } state_e;

  state_e state_q, state_d;

  logic [1:0]      func_q;
  logic [11:0]     addr_q;
  logic [XLEN-1:0] rs1_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] pc_q;

  logic accept;
  // func3[2] only selects register vs immediate operand, which decode has already resolved.
  logic unused_func3;
  assign unused_func3 = req_func3[2];

  assign req_ready = (state_q == StIdle);
  assign busy      = ~req_ready;
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      func_q  <= '0;
      addr_q  <= '0;
      rs1_q   <= '0;
      rd_q    <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        func_q <= req_func3[1:0];
        addr_q <= req_csr_addr;
        rs1_q  <= req_rs1;
        rd_q   <= req_rd_addr;
        pc_q   <= req_pc;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_op == 2'b00 && req_func3[1:0] != 2'b00) begin
            state_d = StCsr;
          end else if (req_op == 2'b01) begin
            state_d = StTEpc;
          end else if (req_op == 2'b10) begin
            state_d = StMStat;
          end else begin
            state_d = StErr;
          end
        end
      end
      StTEpc:   state_d = StTCause;
      StTCause: state_d = StTStat;
      StTStat:  state_d = StTVec;
      StMStat:  state_d = StMEpc;
      StCsr, StTVec, StMEpc, StErr: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  logic [XLEN-1:0] stat_v;

  always_comb begin
    csr_raddr      = '0;
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    rd_w_o         = 1'b0;
    rd_addr_o      = '0;
    rd_o           = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    illegal_o      = 1'b0;
    stat_v         = csr_rdata;
    unique case (state_q)
      StCsr: begin
        csr_raddr = addr_q;
        csr_we    = 1'b1;
        csr_waddr = addr_q;
        case (func_q)
          2'b10:   csr_wdata = csr_rdata | rs1_q;
          2'b11:   csr_wdata = csr_rdata & ~rs1_q;
          default: csr_wdata = rs1_q;
        endcase
        rd_w_o    = 1'b1;
        rd_addr_o = rd_q;
        rd_o      = csr_rdata;
      end
      StTEpc: begin
        csr_we    = 1'b1;
        csr_waddr = AddrMepc;
        csr_wdata = pc_q;
      end
      StTCause: begin
        csr_we    = 1'b1;
        csr_waddr = AddrMcause;
        csr_wdata = XLEN'(ECALL_CAUSE);
      end
      StTStat: begin
        // Trap entry: stash MIE in MPIE, disable interrupts, record M-mode as previous.
        csr_raddr     = AddrMstatus;
        stat_v[7]     = csr_rdata[3];
        stat_v[3]     = 1'b0;
        stat_v[12:11] = 2'b11;
        csr_we        = 1'b1;
        csr_waddr     = AddrMstatus;
        csr_wdata     = stat_v;
      end
      StTVec: begin
        csr_raddr      = AddrMtvec;
        redirect_valid = 1'b1;
        redirect_pc    = {csr_rdata[XLEN-1:2], 2'b00};
      end
      StMStat: begin
        csr_raddr     = AddrMstatus;
        stat_v[3]     = csr_rdata[7];
        stat_v[7]     = 1'b1;
        stat_v[12:11] = 2'b11;
        csr_we        = 1'b1;
        csr_waddr     = AddrMstatus;
        csr_wdata     = stat_v;
      end
      StMEpc: begin
        csr_raddr      = AddrMepc;
        redirect_valid = 1'b1;
        redirect_pc    = csr_rdata;
      end
      StErr:   illegal_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pri_ctrl.sv
// Scoreboard bench for pri_ctrl: directed requests push expected CSR/RF/redirect/illegal
// events; a negedge monitor pops and compares every event the DUT presents.
module tb_pri_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [2:0]  req_func3;
  logic [11:0] req_csr_addr;
  logic [63:0] req_rs1;
  logic [4:0]  req_rd_addr;
  logic [63:0] req_pc;
  logic [11:0] csr_raddr;
  logic [63:0] csr_rdata;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata;
  logic        rd_w_o;
  logic [4:0]  rd_addr_o;
  logic [63:0] rd_o;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        illegal_o;
  logic        busy;

  pri_ctrl #(
    .XLEN        (64),
    .ECALL_CAUSE (11)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_func3      (req_func3),
    .req_csr_addr   (req_csr_addr),
    .req_rs1        (req_rs1),
    .req_rd_addr    (req_rd_addr),
    .req_pc         (req_pc),
    .csr_raddr      (csr_raddr),
    .csr_rdata      (csr_rdata),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .rd_w_o         (rd_w_o),
    .rd_addr_o      (rd_addr_o),
    .rd_o           (rd_o),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .illegal_o      (illegal_o),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file model: combinational read, write on posedge; preload port for test setup.
  logic [63:0] csr_mem [4096];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [63:0] pl_data;

  assign csr_rdata = csr_mem[csr_raddr];

  always @(posedge clk) begin
    if (pl_en) csr_mem[pl_addr] <= pl_data;
    else if (csr_we) csr_mem[csr_waddr] <= csr_wdata;
  end

  typedef struct {
    int          kind;  // 0 CSR write, 1 RF write, 2 redirect, 3 illegal
    logic [63:0] a;
    logic [63:0] d;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  accept_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [63:0] a, input logic [63:0] d);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.d    = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [63:0] a, input logic [63:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d addr 0x%0h data 0x%0h, expected none",
               kind, a, d);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      chk("event_addr", a, e.a);
      chk("event_data", d, e.d);
    end
  endtask

  // Monitor: one fixed observation order per cycle (CSR write, RF write, redirect, illegal).
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid && req_ready) accept_cnt++;
      if (csr_we)         observe(0, 64'(csr_waddr), csr_wdata);
      if (rd_w_o)         observe(1, 64'(rd_addr_o), rd_o);
      if (redirect_valid) observe(2, 64'd0, redirect_pc);
      if (illegal_o)      observe(3, 64'd0, 64'd0);
    end
  end

  task automatic preload(input logic [11:0] addr, input logic [63:0] data);
    pl_en   = 1'b1;
    pl_addr = addr;
    pl_data = data;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  // Presents a request and returns 1 time unit after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [11:0] addr,
                      input logic [63:0] rs1, input logic [4:0] rd, input logic [63:0] pc,
                      input bit hold);
    bit took;
    int n;
    took         = 1'b0;
    n            = 0;
    req_op       = op;
    req_func3    = f3;
    req_csr_addr = addr;
    req_rs1      = rs1;
    req_rd_addr  = rd;
    req_pc       = pc;
    req_valid    = 1'b1;
    while (!took && n < 20) begin
      took = req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!took) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no acceptance in %0d cycles, expected acceptance", n);
    end
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int acc0;

  initial begin
    for (int i = 0; i < 4096; i++) csr_mem[i] = 64'd0;
    rst_n = 1'b0;  req_valid = 1'b0;  req_op = 2'b00;  req_func3 = 3'b000;
    req_csr_addr = '0;  req_rs1 = '0;  req_rd_addr = '0;  req_pc = '0;
    pl_en = 1'b0;  pl_addr = '0;  pl_data = '0;
    #12;
    chk("reset_ready", 64'(req_ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_csr_we", 64'(csr_we), 64'd0);
    chk("reset_rd_w", 64'(rd_w_o), 64'd0);
    chk("reset_redirect", 64'(redirect_valid), 64'd0);
    chk("reset_illegal", 64'(illegal_o), 64'd0);
    chk("reset_raddr", 64'(csr_raddr), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // CSRRS mstatus: 0x8 | 0x80
    preload(12'h300, 64'h8);
    expect_ev(0, 64'h300, 64'h88);
    expect_ev(1, 64'd5, 64'h8);
    send(2'b00, 3'b010, 12'h300, 64'h80, 5'd5, 64'd0, 1'b0);
    @(negedge clk);
    chk("csr_busy_active", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("csr_ready_after", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;

    // CSRRC mcause: 0xF & ~0x3
    preload(12'h342, 64'hF);
    expect_ev(0, 64'h342, 64'hC);
    expect_ev(1, 64'd6, 64'hF);
    send(2'b00, 3'b011, 12'h342, 64'h3, 5'd6, 64'd0, 1'b0);
    idle(2);

    // CSRRW
    preload(12'h340, 64'hABCD);
    expect_ev(0, 64'h340, 64'h1234);
    expect_ev(1, 64'd7, 64'hABCD);
    send(2'b00, 3'b001, 12'h340, 64'h1234, 5'd7, 64'd0, 1'b0);
    idle(2);

    // CSRRSI form (func3[2]=1), rd=0 still writes back
    expect_ev(0, 64'h340, 64'h1235);
    expect_ev(1, 64'd0, 64'h1234);
    send(2'b00, 3'b110, 12'h340, 64'h1, 5'd0, 64'd0, 1'b0);
    idle(2);

    // ECALL
    preload(12'h300, 64'h8);
    preload(12'h305, 64'h80000101);
    expect_ev(0, 64'h341, 64'h80000010);
    expect_ev(0, 64'h342, 64'd11);
    expect_ev(0, 64'h300, 64'h1880);
    expect_ev(2, 64'd0, 64'h80000100);
    send(2'b01, 3'b000, 12'h000, 64'd0, 5'd0, 64'h80000010, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ecall_busy", 64'(busy), 64'd1);
    end
    @(negedge clk);
    chk("ecall_done", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // MRET (mstatus currently 0x1880)
    preload(12'h341, 64'h80000014);
    expect_ev(0, 64'h300, 64'h1888);
    expect_ev(2, 64'd0, 64'h80000014);
    send(2'b10, 3'b000, 12'h000, 64'd0, 5'd0, 64'd0, 1'b0);
    idle(3);

    // Illegal requests
    expect_ev(3, 64'd0, 64'd0);
    send(2'b11, 3'b001, 12'h300, 64'hFF, 5'd1, 64'd0, 1'b0);
    idle(2);
    expect_ev(3, 64'd0, 64'd0);
    send(2'b00, 3'b000, 12'h300, 64'hFF, 5'd1, 64'd0, 1'b0);
    idle(2);
    expect_ev(3, 64'd0, 64'd0);
    send(2'b00, 3'b100, 12'h300, 64'hFF, 5'd1, 64'd0, 1'b0);
    idle(2);

    // Reset during T_CAUSE
    preload(12'h300, 64'h8);
    preload(12'h341, 64'd0);
    expect_ev(0, 64'h341, 64'h80000020);
    send(2'b01, 3'b000, 12'h000, 64'd0, 5'd0, 64'h80000020, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_ready", 64'(req_ready), 64'd1);
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_csr_we", 64'(csr_we), 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    chk("midreset_mepc", csr_mem[12'h341], 64'h80000020);
    chk("midreset_mstatus", csr_mem[12'h300], 64'h8);
    chk("midreset_mcause", csr_mem[12'h342], 64'd11);

    // Back-to-back with req_valid held (0x340 holds 0x1235)
    acc0 = accept_cnt;
    expect_ev(0, 64'h340, 64'h1);
    expect_ev(1, 64'd1, 64'h1235);
    expect_ev(0, 64'h340, 64'h3);
    expect_ev(1, 64'd2, 64'h1);
    expect_ev(3, 64'd0, 64'd0);
    expect_ev(0, 64'h340, 64'h2);
    expect_ev(1, 64'd3, 64'h3);
    send(2'b00, 3'b001, 12'h340, 64'h1, 5'd1, 64'd0, 1'b1);
    send(2'b00, 3'b010, 12'h340, 64'h2, 5'd2, 64'd0, 1'b1);
    send(2'b11, 3'b000, 12'h000, 64'd0, 5'd0, 64'd0, 1'b1);
    send(2'b00, 3'b011, 12'h340, 64'h1, 5'd3, 64'd0, 1'b0);
    idle(3);
    chk("b2b_accepts", 64'(accept_cnt - acc0), 64'd4);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
